shared_ram: RTL
===============

# shared_ram

Multi-channel arbitrated front end to a single-port synchronous RAM. It lets the CPU, video fetch and future DMA/tape masters share one memory array instead of each owning a private `ram` instance. Each channel issues single-word read/write requests. A round-robin or fixed-priority arbiter grants one request per cycle, and read data returns one cycle after the grant on a shared bus, tagged per channel.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, word address width; depth = 2**ADDR_WIDTH.
- `DATA_WIDTH`, 8, word width.
- `N_CH`, 2, number of requesting channels, 1..8.
- `ARB_MODE`, `ARB_RR`, arbitration mode from `shared_ram_pkg`: `ARB_RR` (round robin) or `ARB_FIXED` (lowest index wins).

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_CH  per-channel request.
- `we`  in  N_CH  per-channel write enable, qualified by `req`.
- `addr`  in  N_CH*ADDR_WIDTH  flattened addresses; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- `wdata`  in  N_CH*DATA_WIDTH  flattened write data, same packing.
- `gnt`  out  N_CH  one-hot-or-zero grant, combinational, same cycle as the accepted request.
- `rvalid`  out  N_CH  one-hot-or-zero, registered; marks `rdata` as belonging to that channel.
- `rdata`  out  DATA_WIDTH  shared registered read data bus.

## Operation
- Master protocol: a channel raises `req` and holds `we`/`addr`/`wdata` stable until it sees `gnt[i]`=1. The access is performed in that cycle. The channel may keep `req` high to issue back-to-back requests.
- At most one `gnt` bit is high per cycle. `gnt[i]` implies `req[i]`.
- Write: on grant with `we`=1, `mem[addr_i] <= wdata_i`. No `rvalid` is produced.
- Read: on grant with `we`=0, `rdata <= mem[addr_i]` and `rvalid <= 1<<i` on the next edge. Otherwise `rvalid <= 0`.
- `rdata` holds its last value when `rvalid`=0.
- Read-first memory: a read sees contents before any write in the same cycle. Only one access can occur per cycle, so there is no intra-cycle collision.
- `ARB_RR` mode:
  - Register `ptr` (width clog2(N_CH), min 1) names the highest-priority channel.
  - The search runs ptr, ptr+1, … wrapping modulo N_CH. The first requester wins.
  - After a grant to channel g, `ptr <= (g==N_CH-1) ? 0 : g+1`. With no grant, `ptr` is unchanged.
- `ARB_FIXED` mode: the lowest-index requester wins. `ptr` is unused and held at 0.
- `N_CH`=1: `gnt = req`, with no arbitration logic.
- Reset:
  - `gnt` is forced to 0 in the reset cycle, so no write occurs.
  - `ptr <= 0`, `rvalid <= 0`, `rdata <= 0`.
  - A read granted the cycle before `rst` still updates `rdata`/`rvalid` on the reset edge. That `rvalid` is then cleared by reset, so a read in flight across reset is dropped.
  - Memory contents are not reset.

## Timing
- Grant latency: 0 cycles from `req` when the channel is highest-priority requester.
- Worst-case wait in `ARB_RR`: N_CH-1 grant cycles.
- Read latency: `rvalid`/`rdata` appear exactly 1 cycle after the `gnt` cycle.
- Throughput: one access per cycle in aggregate. A single uncontested channel gets 100 %.
- Combinational path: `req` → `gnt`. Masters must not make `req` depend combinationally on `gnt`.
- First cycle after `rst` deasserts: arbitration proceeds normally with `ptr`=0.

## Structure
- `shared_ram_pkg`: `arb_mode_e` {`ARB_RR`, `ARB_FIXED`} and a `clog2`-safe pointer-width function.
- Sub-module `rr_arbiter` (params `N`, `MODE`):
  - inputs `clk`, `rst`, `req`, `advance`;
  - outputs `gnt` (one-hot-or-zero) and `gnt_idx`;
  - owns `ptr`.
- `shared_ram` contains:
  - the channel mux on `gnt_idx`;
  - the inferred memory array (same read-first style as `ram`);
  - the `rvalid`/`rdata` registers.

## Test plan
- **Single channel write/read** (N_CH=2, RR): ch0 writes 0xA5 @0x1234, then reads @0x1234 → `gnt[0]` both cycles; next cycle `rvalid`=2'b01, `rdata`=0xA5.
- **Round-robin fairness**: both channels read continuously from reset → grants alternate ch0, ch1, ch0, ch1…; `rvalid` alternates one cycle behind.
- **Fixed priority**: ARB_FIXED, N_CH=3, all req high for 4 cycles → `gnt`=3'b001 every cycle; ch1/ch2 hold inputs unchanged until ch0 drops `req`.
- **Read-after-write hazard**: cycle n ch1 writes 0x3C @0x0010 (old 0x00); cycle n+1 ch0 reads @0x0010 → `rdata`=0x3C, `rvalid`=2'b01.
- **Reset mid-operation**: `rst` high in the cycle ch0 requests a write of 0xFF @0x0020, with a read granted the cycle before → `gnt`=0 during `rst`; `rvalid`=0 after reset; a later read @0x0020 returns its pre-reset value.
- **Wrap-around**: N_CH=3 RR, ptr at 2, req=3'b011 → ch0 granted, `ptr` becomes 1; next cycle ch1 granted.

Source files
------------

// File: rtl/shared_ram_pkg.sv
// Shared types for the arbitrated RAM front end: arbitration mode and pointer sizing.
package shared_ram_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Pointer is at least one bit wide so a single-channel build still has a legal vector.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_ram_rr_arbiter.sv
// One-grant-per-cycle arbiter, round robin or fixed priority; grant is combinational from req.
module rr_arbiter
  import shared_ram_pkg::*;
#(
  parameter int        N    = 2,
  parameter arb_mode_e MODE = ARB_RR,
  localparam int       PW   = ptr_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            c;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = 0;
    for (int k = 0; k < N; k++) begin
      c = (MODE == ARB_RR) ? ((int'(ptr_q) + k) % N) : k;
      if (!found && req[c]) begin
        found   = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = PW'(c);
      end
    end
    // No access may happen in the reset cycle, so the grant is suppressed here.
    if (rst) begin
      gnt     = '0;
      gnt_idx = '0;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (MODE == ARB_RR && advance) begin
      ptr_d = (int'(gnt_idx) == N - 1) ? '0 : PW'(int'(gnt_idx) + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/shared_ram.sv
// Multi-channel front end to one single-port read-first RAM; reads return 1 cycle after grant,
// tagged by a one-hot rvalid on a shared rdata bus.
module shared_ram
  import shared_ram_pkg::*;
#(
  parameter int        ADDR_WIDTH = 16,
  parameter int        DATA_WIDTH = 8,
  parameter int        N_CH       = 2,
  parameter arb_mode_e ARB_MODE   = ARB_RR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            req,
  input  logic [N_CH-1:0]            we,
  input  logic [N_CH*ADDR_WIDTH-1:0] addr,
  input  logic [N_CH*DATA_WIDTH-1:0] wdata,
  output logic [N_CH-1:0]            gnt,
  output logic [N_CH-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]      rdata
);

  localparam int PW = ptr_width(N_CH);

  logic [PW-1:0]         gnt_idx;
  logic                  any_gnt;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  rd_fire;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [N_CH-1:0]       rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  rr_arbiter #(
    .N    (N_CH),
    .MODE (ARB_MODE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (any_gnt),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign any_gnt   = |gnt;
  assign sel_we    = we[gnt_idx];
  assign sel_addr  = addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign rd_fire   = any_gnt && !sel_we;

  always_ff @(posedge clk) begin
    if (any_gnt && sel_we) mem[sel_addr] <= sel_wdata;
  end

  // Read-first: rdata samples the array before any write lands on the same edge.
  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (rd_fire) begin
      rvalid_d = gnt;
      rdata_d  = mem[sel_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule
